// File: rtl/decrypt_pipe_oh_enc.sv
// Decrypt output stage: one-hot alpha index to ASCII decode feeding a
// show-ahead output FIFO with sticky error/overflow flags and a pop counter.
module decrypt_pipe_oh_enc #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_in,
    input  logic        is_alpha_upper_case_in,
    input  logic        is_alpha_low_case_in,
    input  logic [31:0] extended_shift_data_in,
    output logic        in_ready,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        err_onehot,
    output logic        overflow,
    output logic [15:0] char_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   char_count_q, char_count_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    logic          full, empty, push, pop;
    logic [25:0]   field;
    logic [4:0]    idx;
    logic          onehot, upper, lower, bad_alpha;
    logic [7:0]    char_dec;

    // Decode: both case flags set is treated as upper case.
    always_comb begin
        field  = extended_shift_data_in[31:6];
        idx    = '0;
        for (int unsigned i = 0; i < 26; i++) begin
            if (field[i]) idx = 5'(i);
        end
        onehot    = (field != '0) && ((field & (field - 26'd1)) == '0);
        upper     = is_alpha_upper_case_in;
        lower     = is_alpha_low_case_in && !is_alpha_upper_case_in;
        bad_alpha = (upper || lower) && !onehot;
        if (!(upper || lower))
            char_dec = extended_shift_data_in[7:0];
        else if (!onehot)
            char_dec = 8'h3F;
        else
            char_dec = {3'b000, idx} + (upper ? 8'd65 : 8'd97);
    end

    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = en_in && !full;
    assign pop   = !empty && dout_ready;

    always_comb begin
        wptr_d       = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d       = pop  ? rptr_q + 1'b1 : rptr_q;
        cnt_d        = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        char_count_d = pop ? char_count_q + 16'd1 : char_count_q;
        err_d        = err_q || (push && bad_alpha);
        ovf_d        = ovf_q || (en_in && full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            char_count_q <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            char_count_q <= char_count_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
        end
    end

    // Storage needs no reset: dout is gated to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= char_dec;
    end

    assign in_ready   = !full;
    assign dout_valid = !empty;
    assign dout       = empty ? '0 : mem_q[rptr_q];
    assign err_onehot = err_q;
    assign overflow   = ovf_q;
    assign char_count = char_count_q;

endmodule

// File: doc/decrypt_pipe_oh_enc.md
DECRYPT_PIPE_OH_ENC -- requirements
Module: decrypt_pipe_oh_enc

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en_in  input  1  input-valid from the rotate stage.
REQ-005 SHALL have port is_alpha_upper_case_in  input  1  character is upper-case alpha.
REQ-006 SHALL have port is_alpha_low_case_in  input  1  character is lower-case alpha.
REQ-007 SHALL have port extended_shift_data_in  input  32  bits [31:6] one-hot alpha index 0..25 when alpha; bits [7:0] raw character otherwise.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a character.
REQ-009 SHALL have port dout  output  8  ASCII character at FIFO head.
REQ-010 SHALL have port dout_valid  output  1  dout holds a valid character.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-012 SHALL have port err_onehot  output  1  sticky: an alpha input had an invalid one-hot field.
REQ-013 SHALL have port overflow  output  1  sticky: en_in was asserted while in_ready was 0.
REQ-014 SHALL have port char_count  output  16  number of characters popped.

Function
REQ-015 SHALL decode combinationally: alpha character = index of the set bit in [31:6], plus 65 if upper, plus 97 if lower.
REQ-016 SHALL output 8'h3F for an alpha input whose [31:6] field is zero or has more than one bit set, and SHALL set err_onehot on the write edge.
REQ-017 SHALL treat both case flags set as upper case.
REQ-018 SHALL pass extended_shift_data_in[7:0] unchanged when neither case flag is set; bits [31:8] are ignored.
REQ-019 SHALL push the decoded character into the FIFO on an edge where en_in=1 and in_ready=1.
REQ-020 SHALL drive in_ready = !full, with no same-cycle pop pass-through.
REQ-021 SHALL drop the character and set overflow when en_in=1 and full, even if a pop occurs on the same edge.
REQ-022 SHALL drive dout_valid = !empty; dout SHALL equal the head entry (show-ahead), so a push at edge N gives dout_valid=1 after edge N when the FIFO was empty.
REQ-023 SHALL pop on an edge where dout_valid=1 and dout_ready=1; dout_ready with the FIFO empty SHALL have no effect.
REQ-024 SHALL apply push and pop on the same edge when neither is blocked; occupancy is unchanged.
REQ-025 SHALL wrap read and write pointers modulo FIFO_DEPTH and SHALL track occupancy 0..FIFO_DEPTH.
REQ-026 SHALL increment char_count by 1 per pop, wrapping 16'hFFFF to 0.
REQ-027 SHALL hold dout stable while dout_valid=1 and dout_ready=0.
REQ-028 SHALL clear err_onehot and overflow only on reset.

Reset
REQ-029 SHALL, while rst=0, force empty FIFO, pointers 0, dout_valid=0, dout=0, in_ready=1, err_onehot=0, overflow=0, char_count=0.
REQ-030 SHALL discard all buffered characters on reset asserted mid-operation, with no pop counted.
REQ-031 SHALL accept a push on the first rising edge after rst is released.

Verification
REQ-032 SHALL cover: en_in=1, upper=1, [31:6]=1<<7 -> after one edge dout=8'h48 ('H'), dout_valid=1.
REQ-033 SHALL cover: lower=1, [31:6]=1<<25, then flags 0 with [7:0]=8'h20 -> 'z' (8'h7A) then 8'h20 popped in order; char_count=2.
REQ-034 SHALL cover: upper=1, [31:6]=0 and then =3 -> dout=8'h3F twice, err_onehot=1 until reset.
REQ-035 SHALL cover: dout_ready=0 with 5 pushes at FIFO_DEPTH=4 -> in_ready=0 after the 4th push, 5th dropped, overflow=1, first 4 characters popped intact.
REQ-036 SHALL cover: full FIFO with en_in=1 and dout_ready=1 on the same edge -> 1 pop, push dropped, overflow=1, occupancy=3.
REQ-037 SHALL cover: rst=0 asserted with 2 entries buffered -> dout_valid=0, char_count=0, and a push after release is popped first.
